dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer between N_PORTS core lanes and the single-port DataMemory.
//   Accepts one load/store per grant over a valid/ready handshake and drives the DataMemory
//   port (wren, address, data-in). Captures the returned read data (Q) and returns it to the
//   requesting lane as a one-cycle response pulse. One access is outstanding at a time.
// PARAMETERS
//   N_PORTS       4    number of requesting lanes (>=2)
//   ADDR_W        16   address width (matches DataMemory address)
//   DATA_W        16   data width (matches DataMemory din/Q)
//   READ_LATENCY  1    clock edges from DataMemory sampling the address to Q being valid (>=1)
// PORTS
//   clk          in   1               system clock, all logic on rising edge
//   rst          in   1               synchronous reset, active-high
//   req_valid    in   N_PORTS         per-lane request valid
//   req_we       in   N_PORTS         per-lane write enable (1=store, 0=load)
//   req_addr     in   N_PORTS*ADDR_W  per-lane address; lane i = [i*ADDR_W +: ADDR_W]
//   req_wdata    in   N_PORTS*DATA_W  per-lane store data; lane i = [i*DATA_W +: DATA_W]
//   req_ready    out  N_PORTS         one-hot acceptance pulse to the granted lane
//   resp_valid   out  N_PORTS         one-hot one-cycle completion pulse
//   resp_rdata   out  DATA_W          load data, valid while any resp_valid bit is high
//   mem_wren     out  1               DataMemory write enable
//   mem_addr     out  ADDR_W          DataMemory address
//   mem_din      out  DATA_W          DataMemory write data
//   mem_q        in   DATA_W          DataMemory read data
//   busy         out  1               high in every state except IDLE
// BEHAVIOUR
// - FSM states: IDLE -> ACCESS -> WAIT -> RESP -> IDLE.
// - Reset values:
//     state=IDLE, rr_ptr=0, mem_wren=0, mem_addr=0, mem_din=0,
//     resp_valid=0, resp_rdata=0, busy=0, req_ready=0.
// - IDLE (cycle T):
//     winner = first lane with req_valid set, searching rr_ptr, rr_ptr+1, ... mod N_PORTS.
//     req_ready[winner] is asserted combinationally in T only; it is forced 0 while rst=1.
//     At the edge ending T: latch winner id, we, addr, wdata; rr_ptr <= (winner+1) mod N_PORTS;
//     go to ACCESS. If no lane is valid, stay in IDLE.
// - Requester rule: a lane holds req_valid, req_we, req_addr and req_wdata stable until it sees
//   req_ready. A lane may drop req_valid before it is granted without any effect.
// - ACCESS (T+1):
//     mem_addr/mem_din = latched values; mem_wren = latched we (high this cycle only).
//     Go to WAIT.
// - WAIT (T+2 .. T+1+READ_LATENCY):
//     lasts exactly READ_LATENCY cycles; mem_addr is held; mem_wren=0.
//     At the edge ending the last WAIT cycle: resp_rdata <= (we ? 0 : mem_q); go to RESP.
// - RESP (T+2+READ_LATENCY):
//     resp_valid[granted id]=1 for exactly this cycle; go to IDLE. Stores are acknowledged the
//     same way, with resp_rdata=0.
// - Throughput: one access per READ_LATENCY+3 cycles. No new grant is issued in ACCESS, WAIT
//   or RESP. resp_rdata holds its value until the next capture.
// - mem_addr/mem_din hold their last latched values while idle (no spurious change).
// - Reset mid-operation: at the next edge the FSM goes to IDLE, rr_ptr goes to 0, and the
//   in-flight access is dropped with no resp_valid. A store is dropped only if rst is sampled
//   before ACCESS, because mem_wren is registered-low from the reset edge onward.
// - Address and data pass through unmodified; no arithmetic, no wrap beyond ADDR_W.
// TESTING
//   1. DataMemory mem[0x0005]=0x1234; lane0 load 0x0005 at T -> req_ready[0]@T,
//      mem_addr=0x0005@T+1, resp_valid[0]@T+3, resp_rdata=0x1234.
//   2. lane2 store 0x0010<-0xBEEF, then lane1 load 0x0010 -> mem_wren high exactly 1 cycle
//      (T+1); resp_valid[2]@T+3 with rdata 0; lane1 load returns 0xBEEF.
//   3. After reset all 4 lanes valid simultaneously -> grants 0,1,2,3 at T, T+4, T+8, T+12;
//      each resp_valid one-hot and matching its lane.
//   4. Fairness: after lane1 is served, lanes 1 and 3 both valid -> lane3 granted first,
//      then lane1.
//   5. rst asserted during WAIT of a lane0 load -> no resp_valid, busy=0 next cycle; then lanes
//      2 and 0 valid -> lane0 granted (rr_ptr=0).
//   6. READ_LATENCY=3 build; lane3 load 0x00FF (mem=0x00AA) at T -> resp_valid[3]@T+5,
//      rdata=0x00AA; busy high T+1..T+5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer between N_PORTS core lanes and one
// single-port DataMemory. One access is in flight at a time; each access walks
// IDLE -> ACCESS -> WAIT (READ_LATENCY cycles) -> RESP -> IDLE.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_valid    per-lane request valid
//   req_we       per-lane write enable (1=store, 0=load)
//   req_addr     packed per-lane address, lane i at [i*ADDR_W +: ADDR_W]
//   req_wdata    packed per-lane store data, lane i at [i*DATA_W +: DATA_W]
//   req_ready    one-hot acceptance pulse to the granted lane (combinational, IDLE only)
//   resp_valid   one-hot one-cycle completion pulse
//   resp_rdata   load data (0 for stores), held until the next capture
//   mem_wren     DataMemory write enable (registered, high in ACCESS of a store)
//   mem_addr     DataMemory address (registered, held while idle)
//   mem_din      DataMemory write data (registered, held while idle)
//   mem_q        DataMemory read data
//   busy         high whenever the FSM is not in IDLE
module dmem_arbiter #(
  parameter int N_PORTS      = 4,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS-1:0]        req_we,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  input  logic [N_PORTS*DATA_W-1:0] req_wdata,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [N_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      mem_wren,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_din,
  input  logic [DATA_W-1:0]         mem_q,
  output logic                      busy
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   id_q;
  logic               we_q;
  logic               mem_wren_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_din_q;
  logic [N_PORTS-1:0] resp_valid_q;
  logic [DATA_W-1:0]  resp_rdata_q;

  // Winner search and selected-lane payload
  logic               win_found;
  logic [PTR_W-1:0]   win_id;
  logic [PTR_W-1:0]   ptr_next;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  int unsigned        idx;
  logic [PTR_W-1:0]   idx_w;

  logic               grant;
  logic               capture;
  logic [N_PORTS-1:0] resp_valid_d;

  // Rotating priority: search starts at rr_ptr and wraps modulo N_PORTS.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    idx_w     = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx   = (int'(rr_ptr_q) + k) % N_PORTS;
      idx_w = PTR_W'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_id    = idx_w;
      end
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (PTR_W'(i) == win_id) begin
        win_we    = req_we[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign ptr_next = (win_id == PTR_W'(N_PORTS - 1)) ? '0 : win_id + 1'b1;

  // Next-state and strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant   = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: begin
        cnt_d   = CNT_W'(READ_LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    resp_valid_d = '0;
    req_ready    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      resp_valid_d[i] = capture && (PTR_W'(i) == id_q);
      req_ready[i]    = grant && !rst && (PTR_W'(i) == win_id);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      we_q         <= 1'b0;
      mem_wren_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      // Write strobe lives only in the ACCESS cycle that follows the grant.
      mem_wren_q   <= grant && win_we;
      resp_valid_q <= resp_valid_d;
      if (grant) begin
        rr_ptr_q   <= ptr_next;
        id_q       <= win_id;
        we_q       <= win_we;
        mem_addr_q <= win_addr;
        mem_din_q  <= win_wdata;
      end
      if (capture) begin
        resp_rdata_q <= we_q ? '0 : mem_q;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_wren   = mem_wren_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one READ_LATENCY=1 instance and one READ_LATENCY=3
// instance, each with its own behavioural DataMemory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with READ_LATENCY=1
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_we    = '0;
  logic [63:0] req_addr  = '0;
  logic [63:0] req_wdata = '0;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic [15:0] resp_rdata;
  logic        mem_wren;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_q;
  logic        busy;

  // Instance with READ_LATENCY=3
  logic [3:0]  r3_valid = '0;
  logic [3:0]  r3_we    = '0;
  logic [63:0] r3_addr  = '0;
  logic [63:0] r3_wdata = '0;
  logic [3:0]  r3_ready;
  logic [3:0]  r3_resp_valid;
  logic [15:0] r3_resp_rdata;
  logic        r3_mem_wren;
  logic [15:0] r3_mem_addr;
  logic [15:0] r3_mem_din;
  logic [15:0] r3_mem_q;
  logic        r3_busy;

  dmem_arbiter #(.N_PORTS(4), .ADDR_W(16), .DATA_W(16), .READ_LATENCY(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .mem_wren  (mem_wren),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_q     (mem_q),
    .busy      (busy)
  );

  dmem_arbiter #(.N_PORTS(4), .ADDR_W(16), .DATA_W(16), .READ_LATENCY(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (r3_valid),
    .req_we    (r3_we),
    .req_addr  (r3_addr),
    .req_wdata (r3_wdata),
    .req_ready (r3_ready),
    .resp_valid(r3_resp_valid),
    .resp_rdata(r3_resp_rdata),
    .mem_wren  (r3_mem_wren),
    .mem_addr  (r3_mem_addr),
    .mem_din   (r3_mem_din),
    .mem_q     (r3_mem_q),
    .busy      (r3_busy)
  );

  // Behavioural DataMemories, low 8 address bits decoded, preloaded on the first edge.
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  logic [15:0] p1;
  logic [15:0] p3 [0:2];
  logic        init1 = 1'b0;
  logic        init3 = 1'b0;

  always @(posedge clk) begin
    if (!init1) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 16'h0000;
      mem1[8'h05] <= 16'h1234;
      mem1[8'h20] <= 16'h2222;
      mem1[8'hFF] <= 16'h00AA;
      init1 <= 1'b1;
    end else if (mem_wren) begin
      mem1[mem_addr[7:0]] <= mem_din;
    end
    p1 <= mem1[mem_addr[7:0]];
  end
  assign mem_q = p1;

  always @(posedge clk) begin
    if (!init3) begin
      for (int i = 0; i < 256; i++) mem3[i] <= 16'h0000;
      mem3[8'hFF] <= 16'h00AA;
      init3 <= 1'b1;
    end else if (r3_mem_wren) begin
      mem3[r3_mem_addr[7:0]] <= r3_mem_din;
    end
    p3[0] <= mem3[r3_mem_addr[7:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign r3_mem_q = p3[2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; lanes that saw req_ready drop their request after the edge.
  task automatic cyc();
    logic [3:0] gr;
    logic [3:0] gr3;
    gr  = req_ready;
    gr3 = r3_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~gr;
    r3_valid  = r3_valid & ~gr3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_rd [0:3];
    exp_rd[0] = 16'h1234;
    exp_rd[1] = 16'hBEEF;
    exp_rd[2] = 16'h2222;
    exp_rd[3] = 16'h00AA;

    // Reset state; a request under reset must not be granted.
    rst = 1'b1;
    cyc();
    cyc();
    req_valid = 4'b0001;
    req_addr[0*16 +: 16] = 16'h0005;
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_wren", mem_wren, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_din", mem_din, 16'h0000);
    check("rst_resp", resp_valid, 4'b0000);
    check("rst_rdata", resp_rdata, 16'h0000);
    cyc();

    // Test 1: lane0 load 0x0005
    rst = 1'b0;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    cyc();
    check("t1_addr", mem_addr, 16'h0005);
    check("t1_wren", mem_wren, 1'b0);
    check("t1_busy", busy, 1'b1);
    cyc();
    check("t1_resp_early", resp_valid, 4'b0000);
    cyc();
    check("t1_resp", resp_valid, 4'b0001);
    check("t1_rdata", resp_rdata, 16'h1234);
    cyc();
    check("t1_resp_end", resp_valid, 4'b0000);
    check("t1_idle", busy, 1'b0);
    check("t1_addr_hold", mem_addr, 16'h0005);

    // Test 2: lane2 store 0x0010 <- 0xBEEF, then lane1 load 0x0010
    req_we = 4'b0100;
    req_addr[2*16 +: 16]  = 16'h0010;
    req_wdata[2*16 +: 16] = 16'hBEEF;
    req_valid = 4'b0100;
    #1;
    check("t2_ready", req_ready, 4'b0100);
    check("t2_wren_t0", mem_wren, 1'b0);
    cyc();
    check("t2_wren_t1", mem_wren, 1'b1);
    check("t2_addr", mem_addr, 16'h0010);
    check("t2_din", mem_din, 16'hBEEF);
    cyc();
    check("t2_wren_t2", mem_wren, 1'b0);
    cyc();
    check("t2_wren_t3", mem_wren, 1'b0);
    check("t2_resp", resp_valid, 4'b0100);
    check("t2_rdata", resp_rdata, 16'h0000);
    cyc();
    req_we = 4'b0000;
    req_addr[1*16 +: 16] = 16'h0010;
    req_valid = 4'b0010;
    #1;
    check("t2_ld_ready", req_ready, 4'b0010);
    cyc();
    cyc();
    cyc();
    check("t2_ld_resp", resp_valid, 4'b0010);
    check("t2_ld_rdata", resp_rdata, 16'hBEEF);
    cyc();

    // Test 4: lanes 1 and 3 valid after lane1 was served -> lane3 first
    req_addr[3*16 +: 16] = 16'h0005;
    req_valid = 4'b1010;
    #1;
    check("t4_first", req_ready, 4'b1000);
    cyc();
    check("t4_no_grant_busy", req_ready, 4'b0000);
    cyc();
    cyc();
    check("t4_resp3", resp_valid, 4'b1000);
    check("t4_rdata3", resp_rdata, 16'h1234);
    cyc();
    check("t4_second", req_ready, 4'b0010);
    cyc();
    cyc();
    cyc();
    check("t4_resp1", resp_valid, 4'b0010);
    check("t4_rdata1", resp_rdata, 16'hBEEF);
    cyc();

    // Test 3: after reset, all lanes valid -> grants 0,1,2,3 every 4 cycles
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_addr = {16'h00FF, 16'h0020, 16'h0010, 16'h0005};
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_grant%0d", k), req_ready, 4'b0001 << k);
      cyc();
      cyc();
      cyc();
      check($sformatf("t3_resp%0d", k), resp_valid, 4'b0001 << k);
      check($sformatf("t3_rdata%0d", k), resp_rdata, exp_rd[k]);
      cyc();
    end
    check("t3_drained", req_valid, 4'b0000);

    // Test 5: reset during WAIT of a lane0 load
    req_valid = 4'b0001;
    #1;
    check("t5_ready", req_ready, 4'b0001);
    cyc();
    cyc();
    check("t5_busy_wait", busy, 1'b1);
    rst = 1'b1;
    cyc();
    check("t5_resp_drop", resp_valid, 4'b0000);
    check("t5_busy_drop", busy, 1'b0);
    rst = 1'b0;
    cyc();
    check("t5_resp_none", resp_valid, 4'b0000);
    req_valid = 4'b0101;
    #1;
    check("t5_ptr0", req_ready, 4'b0001);
    cyc();
    cyc();
    cyc();
    check("t5_resp0", resp_valid, 4'b0001);
    check("t5_rdata0", resp_rdata, 16'h1234);
    cyc();
    check("t5_grant2", req_ready, 4'b0100);
    cyc();
    cyc();
    cyc();
    check("t5_resp2", resp_valid, 4'b0100);
    check("t5_rdata2", resp_rdata, 16'h2222);
    cyc();

    // Test 6: READ_LATENCY=3 instance, lane3 load 0x00FF
    r3_addr[3*16 +: 16] = 16'h00FF;
    r3_valid = 4'b1000;
    #1;
    check("t6_ready", r3_ready, 4'b1000);
    check("t6_busy_t0", r3_busy, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("t6_busy_t%0d", k), r3_busy, 1'b1);
      check($sformatf("t6_noresp_t%0d", k), r3_resp_valid, 4'b0000);
    end
    cyc();
    check("t6_resp", r3_resp_valid, 4'b1000);
    check("t6_rdata", r3_resp_rdata, 16'h00AA);
    check("t6_busy_t5", r3_busy, 1'b1);
    cyc();
    check("t6_busy_t6", r3_busy, 1'b0);
    check("t6_resp_end", r3_resp_valid, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
